// File: rtl/metronome_pkg.sv
// Shared types and 7-segment helpers for the metronome_nbeat design.
package metronome_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT_IN = 2'd1,
    RUN      = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order {a,b,c,d,e,f,g}, index = digit.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Beat 0 (stopped) and anything above 9 show blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] beat);
    logic [6:0] pat;
    if ((beat >= 4'd1) && (beat <= 4'd9)) begin
      pat = SEG_DIGIT[beat];
    end else begin
      pat = SEG_BLANK;
    end
    return pat;
  endfunction

endpackage

// File: rtl/metronome_nbeat_tone_gen.sv
// Square-wave tone generator; restart forces the next cycle to begin a fresh high half.
module tone_gen #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] half_period,
  input  logic         restart,
  output logic         wave
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         wrap_s;

  // One extra bit so 2*half_period never overflows the compare.
  assign wrap_s = ({1'b0, cnt_r} + {{W{1'b0}}, 1'b1}) >= {half_period, 1'b0};

  // Next tone phase.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (restart) begin
      cnt_nxt_s = {W{1'b0}};
    end else if (wrap_s) begin
      cnt_nxt_s = {W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + W'(1);
    end
  end

  // Phase counter and registered wave, computed from the next phase so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
      wave  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      wave  <= enable && (cnt_nxt_s < half_period);
    end
  end

endmodule

// File: rtl/metronome_nbeat.sv
// N-beat metronome with runtime beats-per-bar and tempo, accented beat 1, 7-seg beat display.
// Define METRONOME_COUNT_IN_EN to insert a one-bar normal-tone count-in before RUN.
module metronome_nbeat
  import metronome_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int MAX_BEATS   = 9,
  parameter int PERIOD_W    = 28,
  parameter int BEEP_CYC    = CLK_HZ / 5,
  parameter int ACCENT_HALF = 32507,
  parameter int NORMAL_HALF = 48704
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [3:0]          beats_per_bar,
  input  logic [PERIOD_W-1:0] beat_period,
  output logic [6:0]          seg,
  output logic                speaker_out,
  output logic                beat_pulse,
  output logic                bar_pulse
);

  localparam logic [3:0]          MAX_B    = 4'(MAX_BEATS);
  localparam logic [PERIOD_W-1:0] BEEP_LIM = PERIOD_W'(BEEP_CYC);
  localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PER_MIN  = PERIOD_W'(2);
  localparam int MAX_HALF = (ACCENT_HALF > NORMAL_HALF) ? ACCENT_HALF : NORMAL_HALF;
  localparam int TONE_W   = $clog2(2 * MAX_HALF);
  localparam logic [TONE_W-1:0] ACC_H = TONE_W'(ACCENT_HALF);
  localparam logic [TONE_W-1:0] NRM_H = TONE_W'(NORMAL_HALF);

`ifdef METRONOME_COUNT_IN_EN
  localparam state_e START_ST  = COUNT_IN;
  localparam logic   START_BAR = 1'b0;
`else
  localparam state_e START_ST  = RUN;
  localparam logic   START_BAR = 1'b1;
`endif

  state_e              state_r, state_nxt_s;
  logic [3:0]          beat_r, beat_nxt_s;
  logic [PERIOD_W-1:0] per_cnt_r, per_cnt_nxt_s;
  logic [PERIOD_W-1:0] per_eff_r, per_eff_nxt_s;
  logic                beat_pulse_nxt_s, bar_pulse_nxt_s;
  logic                restart_s, boundary_s, tone_en_s;
  logic [3:0]          bpb_now_s;
  logic [PERIOD_W-1:0] per_now_s, beep_lim_s;
  logic [TONE_W-1:0]   half_s;

  // Live clamped settings; only consumed at start/beat boundaries.
  assign bpb_now_s  = (beats_per_bar == 4'd0) ? 4'd1 :
                      (beats_per_bar > MAX_B) ? MAX_B : beats_per_bar;
  assign per_now_s  = (beat_period < PER_MIN) ? PER_MIN : beat_period;
  assign boundary_s = (per_cnt_r == (per_eff_r - PER_ONE));

  // Control FSM next state, beat sequencing and strobes.
  always_comb begin
    state_nxt_s      = state_r;
    beat_nxt_s       = beat_r;
    per_cnt_nxt_s    = per_cnt_r;
    per_eff_nxt_s    = per_eff_r;
    beat_pulse_nxt_s = 1'b0;
    bar_pulse_nxt_s  = 1'b0;
    restart_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_nxt_s      = START_ST;
          beat_nxt_s       = 4'd1;
          per_cnt_nxt_s    = {PERIOD_W{1'b0}};
          per_eff_nxt_s    = per_now_s;
          beat_pulse_nxt_s = 1'b1;
          bar_pulse_nxt_s  = START_BAR;
          restart_s        = 1'b1;
        end else begin
          beat_nxt_s    = 4'd0;
          per_cnt_nxt_s = {PERIOD_W{1'b0}};
        end
      end
      COUNT_IN, RUN: begin
        if (!run) begin
          state_nxt_s   = IDLE;
          beat_nxt_s    = 4'd0;
          per_cnt_nxt_s = {PERIOD_W{1'b0}};
        end else if (boundary_s) begin
          per_cnt_nxt_s    = {PERIOD_W{1'b0}};
          per_eff_nxt_s    = per_now_s;
          beat_pulse_nxt_s = 1'b1;
          restart_s        = 1'b1;
          // Compare against the live value so a lowered bar length wraps immediately.
          if (beat_r >= bpb_now_s) begin
            beat_nxt_s      = 4'd1;
            state_nxt_s     = RUN;
            bar_pulse_nxt_s = 1'b1;
          end else begin
            beat_nxt_s      = beat_r + 4'd1;
            bar_pulse_nxt_s = 1'b0;
          end
        end else begin
          per_cnt_nxt_s = per_cnt_r + PER_ONE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        beat_nxt_s    = 4'd0;
        per_cnt_nxt_s = {PERIOD_W{1'b0}};
      end
    endcase
  end

  // Beep window and pitch for the cycle being entered.
  always_comb begin
    beep_lim_s = (per_eff_nxt_s < BEEP_LIM) ? per_eff_nxt_s : BEEP_LIM;
    tone_en_s  = (state_nxt_s != IDLE) && (per_cnt_nxt_s < beep_lim_s);
    half_s     = ((state_nxt_s == RUN) && (beat_nxt_s == 4'd1)) ? ACC_H : NRM_H;
  end

  // State, counters and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      beat_r     <= 4'd0;
      per_cnt_r  <= {PERIOD_W{1'b0}};
      per_eff_r  <= {PERIOD_W{1'b0}};
      beat_pulse <= 1'b0;
      bar_pulse  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_r     <= beat_nxt_s;
      per_cnt_r  <= per_cnt_nxt_s;
      per_eff_r  <= per_eff_nxt_s;
      beat_pulse <= beat_pulse_nxt_s;
      bar_pulse  <= bar_pulse_nxt_s;
    end
  end

  tone_gen #(.W(TONE_W)) u_tone (
    .clk         (clk),
    .rst         (rst),
    .enable      (tone_en_s),
    .half_period (half_s),
    .restart     (restart_s),
    .wave        (speaker_out)
  );

  assign seg = seg_decode(beat_r);

endmodule

// File: doc/metronome_nbeat.md
Name: metronome_nbeat

Overview:
- Parametrised successor to the fixed 8-beat metronome: runtime-selectable beats per bar (1..MAX_BEATS) and runtime tempo (beat period in clk cycles).
- Accented beep (high tone) on beat 1, normal beep (low tone) on the other beats.
- Drives the current beat number onto a 7-segment display, plus beat/bar strobes for downstream LEDs or loggers.
- Sits between the board clock and the speaker/7-seg pins; run/stop control comes from a debounced switch.

Parameters:
- CLK_HZ, 27000000, board clock frequency; used only for default derivation.
- MAX_BEATS, 9, upper clamp for beats_per_bar (must be 1..9).
- PERIOD_W, 28, width of the beat_period input.
- BEEP_CYC, CLK_HZ/5, beep length in cycles from each beat start.
- ACCENT_HALF, 32507, half-period in cycles of the beat-1 tone (about 415 Hz).
- NORMAL_HALF, 48704, half-period in cycles of the other-beat tone (about 277 Hz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  high = metronome running; low = stopped.
- beats_per_bar  in  4  beats per bar; sampled at bar/beat boundaries.
- beat_period  in  PERIOD_W  cycles per beat; sampled at beat boundaries.
- seg  out  7  {a,b,c,d,e,f,g}, active-high segments.
- speaker_out  out  1  square-wave tone.
- beat_pulse  out  1  one-cycle strobe at each beat start.
- bar_pulse  out  1  one-cycle strobe at each beat-1 start.

Behaviour:
- Reset (async, any time): state=IDLE, beat=0, all counters 0, speaker_out=0, beat_pulse=0, bar_pulse=0, seg=7'b0000000 (blank).
- Control FSM, IDLE -> RUN:
  - Occurs on the first cycle run=1 is seen in IDLE.
  - Latch bpb_eff and per_eff.
  - beat=1, period counter=0, tone counter=0.
  - Registered outputs: beat_pulse=1 and bar_pulse=1 appear 1 cycle after run is sampled high.
- RUN -> IDLE:
  - Occurs on the first cycle run=0 is seen.
  - Next cycle: speaker_out=0, beat=0, seg blank, no pulses.
  - A partial beep is cut immediately. Re-asserting run restarts at beat 1.
- Clamping:
  - bpb_eff = 1 if beats_per_bar==0; MAX_BEATS if beats_per_bar>MAX_BEATS; else beats_per_bar.
  - per_eff = max(beat_period, 2).
- Beat timing:
  - Period counter counts 0..per_eff-1. Reaching per_eff-1 starts the next beat on the following cycle.
  - Beat start: beat <= (beat>=bpb_eff) ? 1 : beat+1. Re-latch bpb_eff and per_eff.
  - beat_pulse on every beat start; bar_pulse when the new beat==1.
  - If bpb_eff is lowered below the current beat, the next beat wraps to 1.
- Beep:
  - Active while period counter < min(BEEP_CYC, per_eff).
  - Tone counter counts 0..2*H-1 and wraps; speaker_out=1 while counter<H, else 0. H=ACCENT_HALF on beat 1, NORMAL_HALF otherwise.
  - Tone counter resets to 0 at every beat start, so each beep starts high.
  - speaker_out=0 outside the beep window.
  - Beep longer than the beat is truncated by the next beat start.
- 7-seg: combinational decode of beat.
  - 0 shows blank.
  - 1..9 use standard patterns: 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Others show blank.
- Widths: tone counter is wide enough for 2*max(H)-1. All compares are unsigned; there is no overflow path because counters wrap explicitly.

Optional Feature:
- Macro: METRONOME_COUNT_IN_EN.
- Defined:
  - Adds a COUNT_IN FSM state between IDLE and RUN: one full bar of bpb_eff beats, all with the normal tone, with seg showing the beat number.
  - bar_pulse is suppressed during count-in; beat_pulse still fires.
  - After the last count-in beat, enter RUN at beat 1 with the accent, and assert bar_pulse.
  - run=0 during count-in returns to IDLE.
- Undefined: IDLE goes directly to RUN as described above.

Decomposition:
- Package metronome_pkg: state enum (IDLE, COUNT_IN, RUN), the 7-seg pattern constants for digits 0..9 plus blank, and a function seg_decode(beat) returning the 7-bit pattern.
- One natural sub-module, tone_gen: enable, half_period and restart inputs; outputs the square wave.

Test Plan (override BEEP_CYC=6, ACCENT_HALF=2, NORMAL_HALF=3):
- rst pulsed mid-beep with run=1 -> same cycle: speaker_out=0, seg=0000000, pulses 0; after release, restart at beat 1 with both pulses.
- run=1, beats_per_bar=3, beat_period=20:
  - beat_pulse every 20 cycles; bar_pulse every 60 cycles.
  - seg cycles 0110000, 1101101, 1111001.
  - Beat 1 speaker pattern is 1,1,0,0,1,1 then 0 for the rest of the beat.
  - Beats 2/3 pattern is 1,1,1,0,0,0 then 0.
- beats_per_bar=0 -> every beat is beat 1 with accent and bar_pulse. beats_per_bar=15 -> counts to 9 then wraps to 1.
- beat_period=4 -> beep truncated after 4 cycles, tone restarts high each beat. beat_period=1 -> behaves as period 2.
- beats_per_bar changed 8->2 while at beat 5 -> next beat is 1. beat_period changed mid-beat -> takes effect only from the next beat.
- With METRONOME_COUNT_IN_EN and beats_per_bar=4, period 20 -> 4 normal-tone beats with no bar_pulse, then beat 1 accent plus bar_pulse at cycle 80.
